// File: rtl/xsleena_sdr_rom_arbiter.sv
// Round-robin arbiter that puts the OBJ/BACK1/BACK2 graphics-ROM ports onto one SDRAM read port.
// Optional per-channel 1-entry hit cache: define XS_SDR_HITCACHE_EN.
module xsleena_sdr_rom_arbiter #(
    parameter int AW      = 25,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] obj_addr,
    input  logic          obj_req,
    output logic          obj_rdy,
    output logic [DW-1:0] obj_dout,
    input  logic [AW-1:0] bg1_addr,
    input  logic          bg1_req,
    output logic          bg1_rdy,
    output logic [DW-1:0] bg1_dout,
    input  logic [AW-1:0] bg2_addr,
    input  logic          bg2_req,
    output logic          bg2_rdy,
    output logic [DW-1:0] bg2_dout,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state, state_nxt;
    logic [2:0]    req;
    logic [AW-1:0] ch_addr [0:2];
    logic [2:0]    done_q;
    logic [2:0]    elig;
    logic [1:0]    ptr;
    logic [1:0]    grant;
    logic [1:0]    pick;
    logic          pick_valid;
    logic          hit;
    logic          abort_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] cnt;
    logic [2:0]    rdy_q;
    logic [DW-1:0] dout_q [0:2];

    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign req        = {bg2_req, bg1_req, obj_req};
    assign ch_addr[0] = obj_addr;
    assign ch_addr[1] = bg1_addr;
    assign ch_addr[2] = bg2_addr;
    assign elig       = req & ~done_q;

    assign obj_rdy  = rdy_q[0];
    assign bg1_rdy  = rdy_q[1];
    assign bg2_rdy  = rdy_q[2];
    assign obj_dout = dout_q[0];
    assign bg1_dout = dout_q[1];
    assign bg2_dout = dout_q[2];

    // First eligible channel, scanning from the round-robin pointer
    always_comb begin
        pick_valid = 1'b0;
        pick       = ptr;
        for (int unsigned i = 0; i < 3; i++) begin
            int unsigned idx;
            idx = 32'(ptr) + i;
            if (idx >= 3) idx = idx - 3;
            if (!pick_valid && elig[idx]) begin
                pick_valid = 1'b1;
                pick       = 2'(idx);
            end
        end
    end

`ifdef XS_SDR_HITCACHE_EN
    logic [2:0]    c_valid;
    logic [AW-1:0] c_addr [0:2];
    logic [DW-1:0] c_data [0:2];

    assign hit = pick_valid && c_valid[pick] && (c_addr[pick] == ch_addr[pick]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_valid <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                c_addr[i] <= '0;
                c_data[i] <= '0;
            end
        end else if (state == S_WAIT && mem_ack) begin
            c_valid[grant] <= 1'b1;
            c_addr[grant]  <= addr_q;
            c_data[grant]  <= mem_data;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid && !hit) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_ack)                         state_nxt = S_IDLE;
                else if (cnt == CW'(TIMEOUT - 1))    state_nxt = S_ISSUE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = (state == S_ISSUE);
        mem_addr = addr_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdy_q   <= '0;
            done_q  <= '0;
            ptr     <= 2'd0;
            grant   <= 2'd0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            cnt     <= '0;
            for (int unsigned i = 0; i < 3; i++) dout_q[i] <= '0;
        end else begin
            rdy_q  <= '0;
            done_q <= done_q & req;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick;
                        addr_q  <= ch_addr[pick];
                        abort_q <= 1'b0;
`ifdef XS_SDR_HITCACHE_EN
                        if (hit) begin
                            rdy_q[pick]  <= 1'b1;
                            dout_q[pick] <= c_data[pick];
                            done_q[pick] <= 1'b1;
                            ptr          <= next_ch(pick);
                        end
`endif
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (!req[grant]) abort_q <= 1'b1;
                    if (mem_ack) begin
                        ptr <= next_ch(grant);
                        // done is set together with rdy so the still-high req is not re-granted
                        if (req[grant] && !abort_q) begin
                            rdy_q[grant]  <= 1'b1;
                            dout_q[grant] <= mem_data;
                            done_q[grant] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xsleena_sdr_rom_arbiter.sv
// Directed bench for xsleena_sdr_rom_arbiter; cache vectors run when XS_SDR_HITCACHE_EN is defined.
module tb_xsleena_sdr_rom_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] obj_addr, bg1_addr, bg2_addr;
    logic          obj_req, bg1_req, bg2_req;
    logic          obj_rdy, bg1_rdy, bg2_rdy;
    logic [DW-1:0] obj_dout, bg1_dout, bg2_dout;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [DW-1:0] mem_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    xsleena_sdr_rom_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .obj_addr(obj_addr), .obj_req(obj_req), .obj_rdy(obj_rdy), .obj_dout(obj_dout),
        .bg1_addr(bg1_addr), .bg1_req(bg1_req), .bg1_rdy(bg1_rdy), .bg1_dout(bg1_dout),
        .bg2_addr(bg2_addr), .bg2_req(bg2_req), .bg2_rdy(bg2_rdy), .bg2_dout(bg2_dout),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic get_rdy(input int c);
        case (c)
            0: return obj_rdy;
            1: return bg1_rdy;
            default: return bg2_rdy;
        endcase
    endfunction

    function automatic logic [DW-1:0] get_dout(input int c);
        case (c)
            0: return obj_dout;
            1: return bg1_dout;
            default: return bg2_dout;
        endcase
    endfunction

    task automatic set_req(input int c, input logic v);
        case (c)
            0: obj_req = v;
            1: bg1_req = v;
            default: bg2_req = v;
        endcase
    endtask

    // mem_ack pulse; returns at the sample point where rdy should be visible
    task automatic ack(input logic [DW-1:0] d);
        mem_ack  = 1'b1;
        mem_data = d;
        tick();
        mem_ack  = 1'b0;
        mem_data = '0;
    endtask

    task automatic wait_rd(input string tag, input logic [AW-1:0] exp_addr);
        int n = 0;
        while (!mem_rd && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(mem_rd), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        RST = 1'b1;
        obj_addr = '0; bg1_addr = '0; bg2_addr = '0;
        obj_req = 0; bg1_req = 0; bg2_req = 0;
        mem_ack = 0; mem_data = '0;
        repeat (3) tick();
        chk("rst_rdy", {29'd0, obj_rdy, bg1_rdy, bg2_rdy}, 32'd0);
        chk("rst_dout", {obj_dout, bg1_dout} | 32'(bg2_dout), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        RST = 1'b0;
        tick();

        // single OBJ read, ack 5 cycles after issue
        obj_addr = 25'h000123; obj_req = 1;
        tick();
        chk("t1_rd", 32'(mem_rd), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h123);
        tick();
        chk("t1_rd_pulse", 32'(mem_rd), 32'd0);
        repeat (4) tick();
        ack(16'hBEEF);
        chk("t1_rdy", 32'(obj_rdy), 32'd1);
        chk("t1_dout", 32'(obj_dout), 32'hBEEF);
        chk("t1_other_rdy", 32'({bg1_rdy, bg2_rdy}), 32'd0);
        tick();
        chk("t1_rdy_pulse", 32'(obj_rdy), 32'd0);
        chk("t1_no_reissue", 32'(mem_rd), 32'd0);
        chk("t1_dout_hold", 32'(obj_dout), 32'hBEEF);
        obj_req = 0;
        tick();

        // three simultaneous requesters, two full rounds
        do_reset();
        obj_addr = 25'h100; bg1_addr = 25'h200; bg2_addr = 25'h300;
        obj_req = 1; bg1_req = 1; bg2_req = 1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                a = 25'((c + 1) * 'h100);
                wait_rd($sformatf("rr%0d_%0d", r, c), a);
                tick();
                ack(16'hA000 + 16'(r * 16 + c));
                chk($sformatf("rr%0d_%0d_rdy", r, c), 32'(get_rdy(c)), 32'd1);
                chk($sformatf("rr%0d_%0d_dout", r, c), 32'(get_dout(c)), 32'hA000 + 32'(r * 16 + c));
                set_req(c, 1'b0);
            end
            tick();
            obj_req = 1; bg1_req = 1; bg2_req = 1;
        end
        obj_req = 0; bg1_req = 0; bg2_req = 0;
        repeat (2) tick();

        // no ack: re-issue every 65 cycles at the latched address
        do_reset();
        bg1_addr = 25'h1ABCDE; bg1_req = 1;
        tick();
        chk("to_first_rd", 32'(mem_rd), 32'd1);
        bg1_addr = 25'h0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!mem_rd && n < 200);
            chk($sformatf("to_period%0d", k), 32'(n), 32'd65);
            chk($sformatf("to_addr%0d", k), 32'(mem_addr), 32'h1ABCDE);
        end
        tick();
        tick();
        ack(16'h1234);
        chk("to_late_rdy", 32'(bg1_rdy), 32'd1);
        chk("to_late_dout", 32'(bg1_dout), 32'h1234);
        bg1_req = 0;
        tick();

        // reset in WAIT, then a stale ack
        obj_addr = 25'h55; obj_req = 1;
        tick();
        tick();
        tick();
        RST = 1'b1; obj_req = 0;
        tick();
        RST = 1'b0;
        ack(16'hDEAD);
        chk("rw_no_rdy", 32'({obj_rdy, bg1_rdy, bg2_rdy}), 32'd0);
        chk("rw_dout", 32'(obj_dout), 32'd0);
        chk("rw_idle", 32'(mem_rd), 32'd0);
        bg1_addr = 25'h77; bg1_req = 1;
        tick();
        chk("rw_next_rd", 32'(mem_rd), 32'd1);
        chk("rw_next_addr", 32'(mem_addr), 32'h77);
        tick();
        ack(16'h7777);
        chk("rw_next_rdy", 32'(bg1_rdy), 32'd1);
        chk("rw_next_dout", 32'(bg1_dout), 32'h7777);
        bg1_req = 0;
        tick();

        // bg2 drops its request while its read is outstanding
        do_reset();
        bg2_addr = 25'h222; bg2_req = 1;
        tick();
        chk("dr_rd_addr", 32'(mem_addr), 32'h222);
        obj_addr = 25'h333; obj_req = 1;
        tick();
        bg2_req = 0;
        tick();
        tick();
        ack(16'h9999);
        chk("dr_no_rdy", 32'({obj_rdy, bg1_rdy, bg2_rdy}), 32'd0);
        chk("dr_dout", 32'(bg2_dout), 32'd0);
        tick();
        chk("dr_next_rd", 32'(mem_rd), 32'd1);
        chk("dr_next_addr", 32'(mem_addr), 32'h333);
        tick();
        ack(16'h3333);
        chk("dr_next_rdy", 32'(obj_rdy), 32'd1);
        chk("dr_dout_keep", 32'(bg2_dout), 32'd0);
        obj_req = 0;
        tick();

`ifdef XS_SDR_HITCACHE_EN
        // repeat read of the same bg1 address served from the cache
        bg1_addr = 25'h444; bg1_req = 1;
        tick();
        chk("hc_miss_rd", 32'(mem_rd), 32'd1);
        tick();
        ack(16'h4444);
        chk("hc_miss_rdy", 32'(bg1_rdy), 32'd1);
        bg1_req = 0;
        tick();
        bg1_req = 1;
        tick();
        chk("hc_hit_rdy", 32'(bg1_rdy), 32'd1);
        chk("hc_hit_dout", 32'(bg1_dout), 32'h4444);
        chk("hc_hit_no_rd", 32'(mem_rd), 32'd0);
        tick();
        chk("hc_hit_no_rd2", 32'(mem_rd), 32'd0);
        chk("hc_hit_pulse", 32'(bg1_rdy), 32'd0);
        bg1_req = 0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
